trail_iir_multi: RTL and testbench
==================================

// Module: trail_iir_multi
// PURPOSE
//  Parametrised glow-trail IIR blender: out = (a*camera + (2^AW - a)*history + 2^(AW-1)) >> AW, per channel.
//  Generalises the fixed 24-bit RGB trail blend to NCH channels of CW bits, with a runtime blend factor.
//  Adds a 3-stage pipeline with valid/ready backpressure and a frame-synchronous alpha update.
//  Sits between the history-buffer read port / camera pixel stream and the history write-back / display path.
// PARAMETERS
//  NCH         3     channel count; channel 0 occupies bits [CW-1:0]
//  CW          8     bits per channel
//  AW          4     blend fraction bits; alpha range 0..2^AW
//  ALPHA_RESET 4     alpha value after reset (AW+1 bits wide)
// PORTS
//  clk_in      in   1         clock; all logic on rising edge
//  rst_n_in    in   1         asynchronous active-low reset
//  valid_in    in   1         input pixel valid
//  ready_out   out  1         block can accept input this cycle
//  sof_in      in   1         start-of-frame flag, qualified by valid_in
//  alpha_in    in   AW+1      requested blend factor, sampled only at accepted sof
//  history_in  in   NCH*CW    stored trail pixel
//  camera_in   in   NCH*CW    live camera pixel
//  update_out  out  NCH*CW    blended pixel
//  sof_out     out  1         sof_in delayed with the pixel
//  valid_out   out  1         update_out valid
//  ready_in    in   1         downstream accepts output
// BEHAVIOUR
//  - Reset (async assert, sync deassert at source): stage valids=0, valid_out=0, sof_out=0, update_out=0, alpha_q=ALPHA_RESET.
//  - Accept = valid_in && ready_out. Output transfer = valid_out && ready_in.
//  - Global advance en = !valid_out || ready_in; ready_out = en (combinational from ready_in, documented path).
//  - When en=0 every stage register (data, sof, valid) holds; no pixel dropped or duplicated.
//  - When en=1 with valid_in=0, a bubble (valid=0) enters stage 1; bubbles collapse normally.
//  - Latency: exactly 3 cycles accept->valid_out with no stall; throughput 1 pixel/cycle.
//  - Stage 1: register history, camera, sof; alpha_eff = (accept && sof_in) ? clamp(alpha_in) : alpha_q.
//      clamp: values > 2^AW become 2^AW. On accepted sof, alpha_q <= clamp(alpha_in); same pixel uses new alpha.
//  - Stage 2: per channel pc = a*cam, ph = (2^AW - a)*hist, each CW+AW+1 bits unsigned.
//  - Stage 3: s = pc + ph + 2^(AW-1); result = s[CW+AW-1:AW] (fits CW bits, no overflow possible).
//  - a=0 -> update_out == history_in exactly; a=2^AW -> update_out == camera_in exactly.
//  - Reset mid-stream: in-flight pixels discarded; valid_out low the cycle after reset asserts.
//  - alpha_in ignored on non-sof or non-accepted cycles (including stalled sof).
// CONFIGURATION
//  TRAIL_MAX_HOLD_EN defined: stage 3 output per channel = max(result, cam) so bright new light
//    appears at full intensity immediately; cam carried to stage 3. Latency unchanged.
//  Not defined: output is the pure IIR result; cam not carried past stage 2.
// STRUCTURE
//  Package trail_pkg: pixel typedef (NCH x CW packed array), alpha typedef, localparam ALPHA_ONE=2^AW,
//    function clamp_alpha.
//  Sub-module trail_iir_lane: one channel's stage-2/3 datapath (multiply, add, round, optional max),
//    stage enable input; instanced NCH times via generate. Top holds valid/sof pipeline, alpha_q, handshake.
// TESTING (NCH=3, CW=8, AW=4, ready_in=1 unless stated)
//  1 hist=000000, cam=123456, a=8 (sof) -> 3 cycles later update_out=091A2B (=123456 with TRAIL_MAX_HOLD_EN).
//  2 hist=FFEEDD, cam=543210, a=4 (sof) -> update_out=D4BFAA (both configs).
//  3 a=0 then a=16 frames, hist=FAF078, cam=123456 -> FAF078, then 123456; alpha_in=31 clamps to 16.
//  4 Back-to-back 3 pixels, ready_in low 2 cycles mid-burst -> ready_out low same cycles, outputs in order, none lost.
//  5 alpha_in changed on non-sof pixels -> output keeps frame alpha; change takes effect at next accepted sof.
//  6 rst_n_in low with 2 pixels in flight -> valid_out=0, update_out=0, alpha_q=ALPHA_RESET asynchronously.

Source files
------------

// File: rtl/trail_pkg.sv
// Shared types and helpers for the glow-trail IIR blender.
//   TRAIL_NCH / TRAIL_CW / TRAIL_AW : default channel count, channel width, alpha fraction bits
//   TRAIL_ALPHA_RESET               : default alpha after reset
//   pixel_t / alpha_t               : default-sized pixel and alpha types
//   clamp_alpha()                   : saturate a requested alpha to 2^aw
package trail_pkg;

    localparam int unsigned TRAIL_NCH         = 3;
    localparam int unsigned TRAIL_CW          = 8;
    localparam int unsigned TRAIL_AW          = 4;
    localparam int unsigned TRAIL_ALPHA_RESET = 4;
    localparam int unsigned ALPHA_ONE         = 1 << TRAIL_AW;

    typedef logic [TRAIL_NCH-1:0][TRAIL_CW-1:0] pixel_t;
    typedef logic [TRAIL_AW:0]                  alpha_t;

    // Width-generic so instances with non-default AW can share it.
    function automatic logic [31:0] clamp_alpha(input logic [31:0] alpha, input int unsigned aw);
        logic [31:0] one;
        one = 32'd1 << aw;
        return (alpha > one) ? one : alpha;
    endfunction

endpackage

// File: rtl/trail_iir_lane.sv
// One channel of the trail blend, pipeline stages 2 and 3.
//   clk_i, rst_ni : clock, async active-low reset
//   en_i          : global pipeline advance; all registers hold when low
//   alpha_i       : stage-1 effective blend factor (0..2^AW)
//   hist_i, cam_i : stage-1 history and camera channel values
//   result_o      : stage-3 blended channel value
// Build option TRAIL_MAX_HOLD_EN: result is max(blend, camera) so new bright light shows at once.
module trail_iir_lane #(
    parameter int unsigned CW = 8,
    parameter int unsigned AW = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    input  logic [AW:0]   alpha_i,
    input  logic [CW-1:0] hist_i,
    input  logic [CW-1:0] cam_i,
    output logic [CW-1:0] result_o
);

    localparam int unsigned PW       = CW + AW + 1;
    localparam int unsigned AlphaOne = 1 << AW;

    logic [AW:0]   beta;
    logic [PW-1:0] pc_d, ph_d, pc_q, ph_q, sum;
    logic [CW-1:0] blend, result_d, result_q;
    logic          unused_sum;

    always_comb begin
        beta  = (AW+1)'(AlphaOne) - alpha_i;
        pc_d  = PW'(alpha_i) * PW'(cam_i);
        ph_d  = PW'(beta) * PW'(hist_i);
        sum   = pc_q + ph_q + PW'(AlphaOne >> 1);
        // Sum never exceeds 2^(CW+AW)-1, so the top bit is always zero.
        blend = sum[CW+AW-1:AW];
    end

    assign unused_sum = ^{sum[PW-1], sum[AW-1:0]};

`ifdef TRAIL_MAX_HOLD_EN
    logic [CW-1:0] cam_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cam_q <= '0;
        end else if (en_i) begin
            cam_q <= cam_i;
        end
    end

    assign result_d = (blend > cam_q) ? blend : cam_q;
`else
    assign result_d = blend;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q     <= '0;
            ph_q     <= '0;
            result_q <= '0;
        end else if (en_i) begin
            pc_q     <= pc_d;
            ph_q     <= ph_d;
            result_q <= result_d;
        end
    end

    assign result_o = result_q;

endmodule

// File: rtl/trail_iir_multi.sv
// Multi-channel glow-trail IIR blender, 3-stage pipeline with valid/ready backpressure:
//   update = (a*camera + (2^AW - a)*history + 2^(AW-1)) >> AW per channel.
// Ports:
//   clk_in, rst_n_in      : clock, async active-low reset
//   valid_in / ready_out  : input handshake (ready_out is combinational from ready_in)
//   sof_in, alpha_in      : start of frame; alpha sampled only on an accepted sof
//   history_in, camera_in : trail and live pixels, channel 0 in the low CW bits
//   update_out, sof_out   : blended pixel and its delayed sof
//   valid_out / ready_in  : output handshake
// Build option TRAIL_MAX_HOLD_EN: output per channel is max(blend, camera).
module trail_iir_multi
    import trail_pkg::*;
#(
    parameter int unsigned NCH         = TRAIL_NCH,
    parameter int unsigned CW          = TRAIL_CW,
    parameter int unsigned AW          = TRAIL_AW,
    parameter int unsigned ALPHA_RESET = TRAIL_ALPHA_RESET
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic              sof_in,
    input  logic [AW:0]       alpha_in,
    input  logic [NCH*CW-1:0] history_in,
    input  logic [NCH*CW-1:0] camera_in,
    output logic [NCH*CW-1:0] update_out,
    output logic              sof_out,
    output logic              valid_out,
    input  logic              ready_in
);

    localparam int unsigned PW = NCH * CW;

    logic          en, accept;
    logic [AW:0]   alpha_q, alpha_eff, alpha1_q;
    logic [PW-1:0] hist1_q, cam1_q;
    logic          valid1_q, sof1_q, valid2_q, sof2_q;

    always_comb begin
        // The whole pipeline moves together; it only stalls when the output is held.
        en        = !valid_out || ready_in;
        ready_out = en;
        accept    = valid_in && en;
        alpha_eff = alpha_q;
        if (accept && sof_in) begin
            alpha_eff = (AW+1)'(clamp_alpha(32'(alpha_in), AW));
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            alpha_q   <= (AW+1)'(ALPHA_RESET);
            alpha1_q  <= '0;
            hist1_q   <= '0;
            cam1_q    <= '0;
            valid1_q  <= 1'b0;
            sof1_q    <= 1'b0;
            valid2_q  <= 1'b0;
            sof2_q    <= 1'b0;
            valid_out <= 1'b0;
            sof_out   <= 1'b0;
        end else begin
            alpha_q <= alpha_eff;
            if (en) begin
                alpha1_q  <= alpha_eff;
                hist1_q   <= history_in;
                cam1_q    <= camera_in;
                valid1_q  <= accept;
                sof1_q    <= accept && sof_in;
                valid2_q  <= valid1_q;
                sof2_q    <= sof1_q;
                valid_out <= valid2_q;
                sof_out   <= sof2_q;
            end
        end
    end

    for (genvar ch = 0; ch < NCH; ch++) begin : g_lane
        trail_iir_lane #(
            .CW (CW),
            .AW (AW)
        ) u_lane (
            .clk_i    (clk_in),
            .rst_ni   (rst_n_in),
            .en_i     (en),
            .alpha_i  (alpha1_q),
            .hist_i   (hist1_q[ch*CW +: CW]),
            .cam_i    (cam1_q[ch*CW +: CW]),
            .result_o (update_out[ch*CW +: CW])
        );
    end

endmodule

// File: tb/tb_trail_iir_multi.sv
module tb_trail_iir_multi;

    localparam int NCH = 3;
    localparam int CW  = 8;
    localparam int AW  = 4;
    localparam int W   = NCH * CW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid_in, ready_out, sof_in, sof_out, valid_out, ready_in;
    logic [AW:0]   alpha_in;
    logic [W-1:0]  history_in, camera_in, update_out;

    always #5 clk = ~clk;

    trail_iir_multi #(
        .NCH         (NCH),
        .CW          (CW),
        .AW          (AW),
        .ALPHA_RESET (4)
    ) dut (
        .clk_in     (clk),
        .rst_n_in   (rst_n),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .sof_in     (sof_in),
        .alpha_in   (alpha_in),
        .history_in (history_in),
        .camera_in  (camera_in),
        .update_out (update_out),
        .sof_out    (sof_out),
        .valid_out  (valid_out),
        .ready_in   (ready_in)
    );

    typedef struct packed {
        logic [W-1:0] d;
        logic         s;
    } exp_t;

    exp_t         exp_q[$];
    int           checks = 0;
    int           errors = 0;
    int           model_alpha = 4;
    logic [W-1:0] last_out;

    localparam logic [W-1:0] T1_EXP =
`ifdef TRAIL_MAX_HOLD_EN
        24'h123456;
`else
        24'h091A2B;
`endif
    localparam logic [W-1:0] RST_EXP =
`ifdef TRAIL_MAX_HOLD_EN
        24'h123456;
`else
        24'h050D16;
`endif

    // Reference blend straight from the arithmetic definition.
    function automatic logic [W-1:0] blend(input logic [W-1:0] h, input logic [W-1:0] c,
                                           input int a);
        logic [W-1:0] r;
        for (int ch = 0; ch < NCH; ch++) begin
            int hv, cv, v;
            hv = int'(h[ch*CW +: CW]);
            cv = int'(c[ch*CW +: CW]);
            v  = (a * cv + (16 - a) * hv + 8) / 16;
`ifdef TRAIL_MAX_HOLD_EN
            if (cv > v) v = cv;
`endif
            r[ch*CW +: CW] = 8'(v);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, expv);
        end
    endtask

    // One cycle: drive at negedge, then monitor both handshakes before the next posedge.
    task automatic step(input logic v, input logic s, input int a, input logic [W-1:0] h,
                        input logic [W-1:0] c, input logic rdy);
        exp_t e;
        @(negedge clk);
        valid_in   = v;
        sof_in     = s;
        alpha_in   = (AW+1)'(a);
        history_in = h;
        camera_in  = c;
        ready_in   = rdy;
        #1;
        if (valid_out && ready_in) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 32'(valid_out), 32'd0);
            end else begin
                e = exp_q.pop_front();
                last_out = update_out;
                check("out_data", 32'(update_out), 32'(e.d));
                check("out_sof", 32'(sof_out), 32'(e.s));
            end
        end
        if (valid_in && ready_out) begin
            if (sof_in) model_alpha = (a > 16) ? 16 : a;
            e.d = blend(h, c, model_alpha);
            e.s = s;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 0, '0, '0, 1'b1);
    endtask

    task automatic pix(input logic s, input int a, input logic [W-1:0] h, input logic [W-1:0] c);
        step(1'b1, s, a, h, c, 1'b1);
        repeat (3) idle();
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) idle();
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        valid_in = 1'b0; sof_in = 1'b0; alpha_in = '0;
        history_in = '0; camera_in = '0; ready_in = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_update", 32'(update_out), 32'd0);
        check("rst_sof", 32'(sof_out), 32'd0);
        check("rst_ready", 32'(ready_out), 32'd1);
        rst_n = 1'b1;

        // Latency and blend at a=8
        step(1'b1, 1'b1, 8, 24'h000000, 24'h123456, 1'b1);
        idle(); check("t1_lat1", 32'(valid_out), 32'd0);
        idle(); check("t1_lat2", 32'(valid_out), 32'd0);
        idle(); check("t1_lat3", 32'(valid_out), 32'd1);
        check("t1_data", 32'(last_out), 32'(T1_EXP));

        pix(1'b1, 4, 24'hFFEEDD, 24'h543210);
        check("t2_data", 32'(last_out), 32'hD4BFAA);

        // Alpha endpoints, including clamp of an oversized request
        pix(1'b1, 0, 24'hFAF078, 24'h123456);
        check("t3_a0", 32'(last_out), 32'hFAF078);
        pix(1'b1, 31, 24'hFAF078, 24'h123456);
        check("t3_a31", 32'(last_out), 32'h123456);

        // Alpha only changes on an accepted sof
        pix(1'b1, 4, 24'hFFEEDD, 24'h543210);
        pix(1'b0, 16, 24'hFFEEDD, 24'h543210);
        check("t5_nonsof", 32'(last_out), 32'hD4BFAA);
        pix(1'b1, 0, 24'hFFEEDD, 24'h543210);
        check("t5_newsof", 32'(last_out), 32'hFFEEDD);

        // Burst with a two-cycle output stall; a stalled sof must not change alpha
        step(1'b1, 1'b1, 8, 24'h102030, 24'hA0B0C0, 1'b1);
        step(1'b1, 1'b0, 8, 24'h405060, 24'h0A0B0C, 1'b1);
        step(1'b1, 1'b0, 8, 24'hFFFFFF, 24'h000000, 1'b1);
        idle();
        step(1'b1, 1'b1, 0, 24'h111111, 24'h222222, 1'b0);
        check("t4_stall1_ready", 32'(ready_out), 32'd0);
        check("t4_stall1_valid", 32'(valid_out), 32'd1);
        step(1'b1, 1'b1, 0, 24'h111111, 24'h222222, 1'b0);
        check("t4_stall2_ready", 32'(ready_out), 32'd0);
        step(1'b1, 1'b0, 0, 24'h333333, 24'h444444, 1'b1);
        drain();

        // Reset with pixels in flight
        step(1'b1, 1'b1, 12, 24'h0F0F0F, 24'hF0F0F0, 1'b1);
        step(1'b1, 1'b0, 12, 24'h0F0F0F, 24'hF0F0F0, 1'b1);
        step(1'b1, 1'b0, 12, 24'h0F0F0F, 24'hF0F0F0, 1'b1);
        idle();
        #2 rst_n = 1'b0;
        #1;
        check("t6_valid", 32'(valid_out), 32'd0);
        check("t6_update", 32'(update_out), 32'd0);
        exp_q.delete();
        model_alpha = 4;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pix(1'b0, 0, 24'h000000, 24'h123456);
        check("t6_alpha_reset", 32'(last_out), 32'(RST_EXP));

        // Randomized traffic against the scoreboard
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0, $urandom_range(0, 31),
                 W'($urandom), W'($urandom), $urandom_range(0, 3) != 0);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
